issue_ibuffer: RTL

Per-warp instruction buffer between decode and the dispatch stage. It holds decoded instructions in one FIFO per warp and picks a warp round-robin among non-empty, issue-eligible warps. It presents one instruction per cycle through a registered valid/ready output to dispatch, which routes it to the ALU/LSU/CSR/FPU/GPU request buffers. The payload is opaque: uuid, tmask, PC, ex_type, op_type, op_mod, imm, rd, wb and the other decoded fields are packed into DATAW bits by the instantiating wrapper.

---
 rtl/issue_ibuffer_if.sv | 28 ++
 rtl/issue_ibuffer.sv | 123 ++++++++++++
 2 files changed

// File: rtl/issue_ibuffer_if.sv
// Decode-to-dispatch handshake bundle for the per-warp instruction buffer.
// The master drives the offer side and out_ready; the slave is the buffer itself.
interface issue_ibuffer_if #(
    parameter int NUM_WARPS = 4,
    parameter int DATAW     = 128,
    parameter int NW_BITS   = 2
);
    logic                 in_valid;
    logic [NW_BITS-1:0]   in_wid;
    logic [DATAW-1:0]     in_data;
    logic                 in_ready;
    logic [NUM_WARPS-1:0] issue_allow;
    logic                 out_valid;
    logic [NW_BITS-1:0]   out_wid;
    logic [DATAW-1:0]     out_data;
    logic                 out_ready;
    logic [NUM_WARPS-1:0] warp_empty;

    modport master (
        output in_valid, in_wid, in_data, issue_allow, out_ready,
        input  in_ready, out_valid, out_wid, out_data, warp_empty
    );

    modport slave (
        input  in_valid, in_wid, in_data, issue_allow, out_ready,
        output in_ready, out_valid, out_wid, out_data, warp_empty
    );
endinterface

// File: rtl/issue_ibuffer.sv
// Per-warp instruction FIFOs with round-robin selection among eligible warps
// into a single registered valid/ready output toward dispatch.
module issue_ibuffer #(
    parameter int NUM_WARPS = 4,
    parameter int DEPTH     = 2,
    parameter int DATAW     = 128,
    parameter int NW_BITS   = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
    input  logic            clk,
    input  logic            reset,
    issue_ibuffer_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATAW-1:0]   r_mem  [NUM_WARPS][DEPTH];
    logic [PTR_W-1:0]   r_wptr [NUM_WARPS];
    logic [PTR_W-1:0]   r_rptr [NUM_WARPS];
    logic [CNT_W-1:0]   r_cnt  [NUM_WARPS];
    logic               r_out_valid;
    logic [NW_BITS-1:0] r_out_wid;
    logic [DATAW-1:0]   r_out_data;
    logic [NW_BITS-1:0] r_rr_last;

    logic                 w_wid_ok;
    logic                 w_in_ready;
    logic                 w_enq;
    logic                 w_load;
    logic                 w_any;
    logic                 w_deq;
    logic [NW_BITS-1:0]   w_sel;
    logic [NUM_WARPS-1:0] w_elig;
    logic [NUM_WARPS-1:0] w_empty;
    logic [NUM_WARPS-1:0] w_inc;
    logic [NUM_WARPS-1:0] w_dec;

    // Acceptance of the offered instruction; a full FIFO never bypasses.
    always_comb begin
        w_wid_ok = (int'(bus.in_wid) < NUM_WARPS);
        if (w_wid_ok) begin
            w_in_ready = (r_cnt[bus.in_wid] < CNT_W'(DEPTH));
        end else begin
            w_in_ready = 1'b0;
        end
        w_enq = bus.in_valid && w_in_ready;
    end

    // Round-robin pick; scanning from the far end lets the nearest hit win.
    always_comb begin
        w_any = 1'b0;
        w_sel = {NW_BITS{1'b0}};
        for (int w = 0; w < NUM_WARPS; w++) begin
            w_elig[w]  = (r_cnt[w] != {CNT_W{1'b0}}) && bus.issue_allow[w];
            w_empty[w] = (r_cnt[w] == {CNT_W{1'b0}});
        end
        for (int k = NUM_WARPS; k >= 1; k--) begin
            w_any = w_any | w_elig[(int'(r_rr_last) + k) % NUM_WARPS];
            w_sel = w_elig[(int'(r_rr_last) + k) % NUM_WARPS]
                  ? NW_BITS'((int'(r_rr_last) + k) % NUM_WARPS) : w_sel;
        end
        w_load = !r_out_valid || bus.out_ready;
        w_deq  = w_load && w_any;
        for (int w = 0; w < NUM_WARPS; w++) begin
            w_inc[w] = w_enq && (bus.in_wid == NW_BITS'(w));
            w_dec[w] = w_deq && (w_sel == NW_BITS'(w));
        end
    end

    // Payload storage; contents are meaningless until counted, so no reset.
    always_ff @(posedge clk) begin
        if (w_enq && reset) begin
            r_mem[bus.in_wid][r_wptr[bus.in_wid]] <= bus.in_data;
        end
    end

    // Per-warp pointers and occupancy counts.
    always_ff @(posedge clk) begin
        for (int w = 0; w < NUM_WARPS; w++) begin
            if (!reset) begin
                r_wptr[w] <= {PTR_W{1'b0}};
                r_rptr[w] <= {PTR_W{1'b0}};
                r_cnt[w]  <= {CNT_W{1'b0}};
            end else begin
                if (w_inc[w]) begin
                    r_wptr[w] <= r_wptr[w] + PTR_W'(1);
                end
                if (w_dec[w]) begin
                    r_rptr[w] <= r_rptr[w] + PTR_W'(1);
                end
                case ({w_inc[w], w_dec[w]})
                    2'b10:   r_cnt[w] <= r_cnt[w] + CNT_W'(1);
                    2'b01:   r_cnt[w] <= r_cnt[w] - CNT_W'(1);
                    default: r_cnt[w] <= r_cnt[w];
                endcase
            end
        end
    end

    // Output register; holds while dispatch stalls regardless of issue_allow.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_out_valid <= 1'b0;
            r_out_wid   <= {NW_BITS{1'b0}};
            r_out_data  <= {DATAW{1'b0}};
            r_rr_last   <= NW_BITS'(NUM_WARPS - 1);
        end else if (w_load) begin
            if (w_any) begin
                r_out_valid <= 1'b1;
                r_out_wid   <= w_sel;
                r_out_data  <= r_mem[w_sel][r_rptr[w_sel]];
                r_rr_last   <= w_sel;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_wid    = r_out_wid;
    assign bus.out_data   = r_out_data;
    assign bus.warp_empty = w_empty;
endmodule
